// File: rtl/bc_mem_arbiter.sv
// Round-robin arbiter sharing the basic-computer memory between the CPU controller
// and the DMA/I-O engine; one transaction at a time, registered memory port and acks.
`timescale 1ns/1ps
module bc_mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_LAT    = 1    // legal range 1..15 (4-bit wait counter)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT);

  state_t                state;
  logic                  last;      // 0 = CPU, 1 = DMA; loser of the next tie
  logic [3:0]            wait_cnt;
  logic                  lat_we;

  logic                  grant_dma;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // On a tie the port that did not win last time is granted.
  assign grant_dma = dma_req && (!cpu_req || !last);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant_dma) begin
      sel_we    = dma_we;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  // mem_addr/mem_wdata double as the latched request, so they hold outside ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b1;
      busy      <= 1'b0;
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            owner     <= grant_dma;
            lat_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_we) begin
            cpu_ack <= !owner;
            dma_ack <= owner;
            state   <= ACK;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            if (owner) dma_rdata <= mem_rdata;
            else       cpu_rdata <= mem_rdata;
            cpu_ack <= !owner;
            dma_ack <= owner;
            state   <= ACK;
          end
        end
        ACK: begin
          last  <= owner;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bc_mem_arbiter.sv
// Bench for bc_mem_arbiter: two instances (MEM_LAT 1 and 3) share stimulus; each is
// compared every cycle against a timestamp-based transaction model, plus literal checks.
`timescale 1ns/1ps
module tb_bc_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;

  logic          cpu_ack [2], dma_ack [2], mem_en [2], mem_we [2], busy [2], owner [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_wdata [2], mem_rdata [2], cpu_rdata [2], dma_rdata [2];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_lat
    localparam int LAT = (k == 0) ? 1 : 3;

    bc_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack[k]), .cpu_rdata(cpu_rdata[k]),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack[k]), .dma_rdata(dma_rdata[k]),
      .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
      .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k]),
      .busy(busy[k]), .owner(owner[k])
    );

    // Memory: read data valid only LAT cycles after the issue cycle, junk otherwise.
    logic [DW-1:0] mem [4096];
    logic [DW-1:0] ref_mem [4096];
    logic          pipe_v [LAT] = '{default: 1'b0};
    logic [DW-1:0] pipe_d [LAT] = '{default: '0};
    logic [DW-1:0] junk = '0;

    initial begin
      for (int i = 0; i < 4096; i++) begin
        mem[i]     = DW'(i * 40503 + 7);
        ref_mem[i] = mem[i];
      end
      mem[12'h123] = 16'hBEEF; ref_mem[12'h123] = 16'hBEEF;
      mem[12'h010] = 16'h0F10; ref_mem[12'h010] = 16'h0F10;
      mem[12'h2A5] = 16'hC0DE; ref_mem[12'h2A5] = 16'hC0DE;
    end

    always @(posedge clk) begin
      pipe_v[0] <= mem_en[k] && !mem_we[k];
      pipe_d[0] <= mem[mem_addr[k]];
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      junk <= DW'($urandom);
      if (mem_en[k] && mem_we[k]) mem[mem_addr[k]] = mem_wdata[k];
    end
    assign mem_rdata[k] = pipe_v[LAT-1] ? pipe_d[LAT-1] : junk;

    // Transaction model: m_g is the edge a request was granted at, m_len the
    // number of edges from grant to the edge that raises ack.
    int            m_cyc = 0, m_g = -1000, m_len = 0, m_owner = 1, m_last = 1;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata [2] = '{default: '0};

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_cyc = 0; m_g = -1000; m_len = 0; m_owner = 1; m_last = 1;
        m_we = 1'b0; m_addr = '0; m_wdata = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;
      end else begin
        m_cyc++;
        if (m_cyc == m_g + 1 && m_we) ref_mem[m_addr] = m_wdata;
        if (m_cyc == m_g + m_len && !m_we) m_rdata[m_owner] = ref_mem[m_addr];
        if (m_cyc >= m_g + m_len + 2 && (cpu_req || dma_req)) begin
          if (cpu_req && dma_req) m_owner = 1 - m_last;
          else                    m_owner = dma_req ? 1 : 0;
          m_last  = m_owner;
          m_we    = (m_owner == 1) ? dma_we    : cpu_we;
          m_addr  = (m_owner == 1) ? dma_addr  : cpu_addr;
          m_wdata = (m_owner == 1) ? dma_wdata : cpu_wdata;
          m_g     = m_cyc;
          m_len   = m_we ? 1 : LAT + 1;
        end
      end
    end

    always @(negedge clk) begin
      bit    e_en, e_ack, e_busy;
      string p;
      p      = (LAT == 1) ? "lat1 " : "lat3 ";
      e_en   = (m_cyc == m_g);
      e_ack  = (m_cyc == m_g + m_len);
      e_busy = (m_cyc >= m_g) && (m_cyc <= m_g + m_len);
      check({p, "mem_en"},    32'(mem_en[k]),    32'(e_en));
      check({p, "mem_we"},    32'(mem_we[k]),    32'(e_en && m_we));
      check({p, "mem_addr"},  32'(mem_addr[k]),  32'(m_addr));
      check({p, "mem_wdata"}, 32'(mem_wdata[k]), 32'(m_wdata));
      check({p, "busy"},      32'(busy[k]),      32'(e_busy));
      check({p, "owner"},     32'(owner[k]),     32'(m_owner));
      check({p, "cpu_ack"},   32'(cpu_ack[k]),   32'(e_ack && m_owner == 0));
      check({p, "dma_ack"},   32'(dma_ack[k]),   32'(e_ack && m_owner == 1));
      check({p, "cpu_rdata"}, 32'(cpu_rdata[k]), 32'(m_rdata[0]));
      check({p, "dma_rdata"}, 32'(dma_rdata[k]), 32'(m_rdata[1]));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (n) tick();
  endtask

  // Issues one request and waits (bounded) for its ack on instance inst.
  task automatic run_txn(input bit port, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int inst,
                         output int lat, output int en_cnt, output logic [AW-1:0] en_addr,
                         output logic [DW-1:0] en_wdata, output bit en_we, output int wrong_acks);
    lat = -1; en_cnt = 0; en_addr = '0; en_wdata = '0; en_we = 1'b0; wrong_acks = 0;
    if (port) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      tick();
      if (mem_en[inst]) begin
        en_cnt++;
        en_addr  = mem_addr[inst];
        en_wdata = mem_wdata[inst];
        en_we    = mem_we[inst];
      end
      if (port ? cpu_ack[inst] : dma_ack[inst]) wrong_acks++;
      if (port ? dma_ack[inst] : cpu_ack[inst]) lat = c;
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(3) == 0) ? AW'($urandom) : AW'($urandom_range(15));
  endfunction

  initial begin
    int            lat, en_cnt, wrong, n_ack, dbl;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    bit            ewe;
    logic [3:0]    ord, own;

    rst = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      check("reset busy",      32'(busy[k]),      32'd0);
      check("reset owner",     32'(owner[k]),     32'd1);
      check("reset mem_en",    32'(mem_en[k]),    32'd0);
      check("reset mem_addr",  32'(mem_addr[k]),  32'd0);
      check("reset cpu_rdata", 32'(cpu_rdata[k]), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Single CPU read of 0x123.
    run_txn(1'b0, 1'b0, 12'h123, 16'h0000, 0, lat, en_cnt, ea, ew, ewe, wrong);
    check("cpu read latency",   32'(lat),          32'd3);
    check("cpu read en cycles", 32'(en_cnt),       32'd1);
    check("cpu read mem_addr",  32'(ea),           32'h123);
    check("cpu read dma_ack",   32'(wrong),        32'd0);
    check("cpu read rdata",     32'(cpu_rdata[0]), 32'hBEEF);
    idle(8);

    // DMA write 0x0FF <= 0x1234, then CPU reads it back.
    run_txn(1'b1, 1'b1, 12'h0FF, 16'h1234, 0, lat, en_cnt, ea, ew, ewe, wrong);
    check("dma write latency",   32'(lat),    32'd2);
    check("dma write en cycles", 32'(en_cnt), 32'd1);
    check("dma write mem_addr",  32'(ea),     32'h0FF);
    check("dma write mem_wdata", 32'(ew),     32'h1234);
    check("dma write mem_we",    32'(ewe),    32'd1);
    idle(8);
    run_txn(1'b0, 1'b0, 12'h0FF, 16'h0000, 0, lat, en_cnt, ea, ew, ewe, wrong);
    check("readback latency", 32'(lat),          32'd3);
    check("readback rdata",   32'(cpu_rdata[0]), 32'h1234);
    idle(8);

    // Lone DMA read leaves last = DMA; CPU rdata must not move.
    run_txn(1'b1, 1'b0, 12'h123, 16'h0000, 0, lat, en_cnt, ea, ew, ewe, wrong);
    check("dma read rdata",      32'(dma_rdata[0]), 32'hBEEF);
    check("non-owner rdata",     32'(cpu_rdata[0]), 32'h1234);
    idle(8);

    // Contention with both requests held.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h2A5;
    n_ack = 0; dbl = 0; ord = '0; own = '0;
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      tick();
      if (cpu_ack[0] && dma_ack[0]) dbl++;
      if (cpu_ack[0] || dma_ack[0]) begin
        ord = {ord[2:0], dma_ack[0]};
        own = {own[2:0], owner[0]};
        n_ack++;
      end
    end
    idle(10);
    check("contention acks",       32'(n_ack),        32'd4);
    check("contention order",      32'(ord),          32'b0101);
    check("contention owner",      32'(own),          32'b0101);
    check("contention double ack", 32'(dbl),          32'd0);
    check("contention cpu rdata",  32'(cpu_rdata[0]), 32'h0F10);
    check("contention dma rdata",  32'(dma_rdata[0]), 32'hC0DE);

    // MEM_LAT = 3 CPU read.
    run_txn(1'b0, 1'b0, 12'h2A5, 16'h0000, 1, lat, en_cnt, ea, ew, ewe, wrong);
    check("lat3 read latency",  32'(lat),          32'd5);
    check("lat3 read mem_addr", 32'(ea),           32'h2A5);
    check("lat3 read rdata",    32'(cpu_rdata[1]), 32'hC0DE);
    idle(10);

    // Address changed after grant, then request dropped before ack.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
    tick();
    check("early drop issue en",   32'(mem_en[0]),   32'd1);
    check("early drop issue addr", 32'(mem_addr[0]), 32'h123);
    cpu_addr = 12'h3FF;
    tick();
    cpu_req = 1'b0;
    check("early drop held addr",  32'(mem_addr[0]), 32'h123);
    n_ack = 0; en_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cpu_ack[0]) n_ack++;
      if (mem_en[0])  en_cnt++;
    end
    check("early drop acks",     32'(n_ack),        32'd1);
    check("early drop reissue",  32'(en_cnt),       32'd0);
    check("early drop rdata",    32'(cpu_rdata[0]), 32'hBEEF);
    idle(10);

    // Reset during WAIT of a CPU read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0FF;
    tick();
    tick();
    check("pre-reset busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    check("mid reset busy",    32'(busy[0]),    32'd0);
    check("mid reset mem_en",  32'(mem_en[0]),  32'd0);
    check("mid reset cpu_ack", 32'(cpu_ack[0]), 32'd0);
    tick();
    check("mid reset rdata",   32'(cpu_rdata[0]), 32'd0);
    rst = 1'b0;
    tick();
    run_txn(1'b0, 1'b0, 12'h010, 16'h0000, 0, lat, en_cnt, ea, ew, ewe, wrong);
    check("post reset latency", 32'(lat),          32'd3);
    check("post reset rdata",   32'(cpu_rdata[0]), 32'h0F10);
    idle(10);

    // Random traffic, including early drops and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!cpu_req) begin
        if ($urandom_range(2) == 0) begin
          cpu_req = 1'b1; cpu_we = 1'($urandom_range(1));
          cpu_addr = rand_addr(); cpu_wdata = DW'($urandom);
        end
      end else if (cpu_ack[0] || $urandom_range(40) == 0) begin
        cpu_req = ($urandom_range(3) == 0); cpu_we = 1'($urandom_range(1));
        cpu_addr = rand_addr(); cpu_wdata = DW'($urandom);
      end
      if (!dma_req) begin
        if ($urandom_range(2) == 0) begin
          dma_req = 1'b1; dma_we = 1'($urandom_range(1));
          dma_addr = rand_addr(); dma_wdata = DW'($urandom);
        end
      end else if (dma_ack[0] || $urandom_range(40) == 0) begin
        dma_req = ($urandom_range(3) == 0); dma_we = 1'($urandom_range(1));
        dma_addr = rand_addr(); dma_wdata = DW'($urandom);
      end
      if ($urandom_range(400) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bc_mem_arbiter.md
Name: bc_mem_arbiter

Overview:
- Shares the single 4K x 16 basic-computer memory between two requesters: the CPU controller (fetch, operand and indirect accesses) and a DMA/I-O engine.
- Grants one transaction at a time with round-robin priority and drives the memory port.
- Returns read data and a one-cycle ack to the winning requester.
- Sits between the controller/datapath and the memory array.

Parameters:
- ADDR_WIDTH, 12, memory address width (AR width).
- DATA_WIDTH, 16, memory word width.
- MEM_LAT, 1, read latency in cycles from the issue cycle to mem_rdata valid. Legal range is 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU request; held with cpu_we/addr/wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  CPU read data; valid with cpu_ack, held until the next CPU read ack.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata: same as the cpu_* set, for the DMA port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  high whenever state != IDLE.
- owner  out  1  current/last grant: 0 = CPU, 1 = DMA.

Behaviour:
- Reset values (asynchronous, any state):
  - state = IDLE.
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_ack = 0, dma_ack = 0, cpu_rdata = 0, dma_rdata = 0.
  - busy = 0, owner = 1.
  - Priority pointer last = DMA, so the CPU wins the first tie.
  - Wait counter = 0.
  - Reset mid-transaction aborts it with no ack.
- State machine:
  - IDLE -> ISSUE: on any sampled request. On the same edge, latch the winner's we/addr/wdata into internal registers and set owner.
  - ISSUE: one cycle. mem_en = 1, mem_we/addr/wdata are driven from the latched registers.
    - Write -> ACK.
    - Read -> WAIT with counter = MEM_LAT.
  - WAIT: decrement the counter each cycle. In the cycle where counter == 1, sample mem_rdata into the owner's rdata register, then go to ACK.
  - ACK: one cycle. Pulse the owner's ack only; the other ack stays 0. Update last = owner. Go to IDLE.
- Latency, measured from the edge where IDLE samples req:
  - Write: ack high 2 cycles later.
  - Read: ack high MEM_LAT+2 cycles later.
  - Minimum turnaround: one IDLE cycle between transactions.
- Arbitration (evaluated only in IDLE):
  - Only cpu_req: grant CPU.
  - Only dma_req: grant DMA.
  - Both: grant the requester that is not last.
  - Two back-to-back contested rounds therefore alternate CPU/DMA, so no port starves.
- Request handling:
  - A req that is still high in the IDLE cycle after its ack is treated as a new transaction.
  - Requests arriving while busy wait for IDLE; they are not queued.
  - Dropping req before ack is a protocol violation. The arbiter completes the latched transaction and still pulses ack.
- Data capture:
  - Inputs are latched at grant. Changes to a granted port's inputs after grant do not affect the memory access.
  - Non-owner rdata never changes.
- Output timing:
  - mem_we is 0 whenever mem_en is 0.
  - mem_addr/mem_wdata hold the latched values outside ISSUE.
- Widths: no arithmetic on data. Wait counter is 4 bits.

Test Plan:
- Reset mid-read:
  - Stimulus: assert rst during WAIT of a CPU read.
  - Required: immediately busy = 0, mem_en = 0, no cpu_ack. After release, a CPU read of 0x010 completes normally.
- Single CPU read, MEM_LAT = 1, memory[0x123] = 0xBEEF:
  - Stimulus: cpu_req with cpu_addr = 0x123, cpu_we = 0.
  - Required: mem_en for exactly 1 cycle with mem_addr = 0x123. cpu_ack 3 cycles after req sampled, with cpu_rdata = 0xBEEF. dma_ack = 0 throughout.
- DMA write:
  - Stimulus: dma_addr = 0x0FF, dma_wdata = 0x1234.
  - Required: mem_en = mem_we = 1 with those values for one cycle. dma_ack 2 cycles after sample. A subsequent CPU read of 0x0FF returns 0x1234.
- Contention with both requests held continuously:
  - Required: grant order CPU, DMA, CPU, DMA.
  - Required: owner toggles each transaction; exactly one ack per transaction.
- MEM_LAT = 3:
  - Stimulus: CPU read.
  - Required: ack 5 cycles after sample. Sampled rdata equals the mem_rdata present 3 cycles after the issue cycle.
- Early request drop:
  - Stimulus: cpu_addr changed after grant, then cpu_req dropped before ack.
  - Required: memory sees the originally latched address, and cpu_ack still pulses once.
